// File: rtl/sub_arbiter.sv
// Round-robin arbiter that shares one signed subtractor (A - B) among R requesters
// and returns each difference tagged with the requester index.

module sub_arbiter_sub #(
    parameter int N = 8
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N+1:0] diff_o
);
    // Two guard bits make the difference of any two N-bit signed values exact.
    assign diff_o = {{2{a_i[N-1]}}, a_i} - {{2{b_i[N-1]}}, b_i};
endmodule

module sub_arbiter #(
    parameter int N   = 8,
    parameter int R   = 4,
    parameter int IDW = 2,
    parameter int CW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [R-1:0]          req_valid,
    input  logic [R*N-1:0]        req_a,
    input  logic [R*N-1:0]        req_b,
    output logic [R-1:0]          req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic signed [N+1:0]   res_diff,
    output logic [IDW-1:0]        res_id,
    output logic                  busy,
    output logic [CW-1:0]         op_count
);

    if (R > (1 << IDW)) begin : g_bad_cfg
        $error("sub_arbiter: R=%0d does not fit in IDW=%0d bits", R, IDW);
    end

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        gnt_q;
    logic [IDW-1:0]        id_q;
    logic [CW-1:0]         count_q, count_d;
    logic signed [N-1:0]   a_q, b_q;
    logic signed [N+1:0]   diff_q;
    logic signed [N+1:0]   sub_diff;
    logic [IDW-1:0]        grant_idx;
    logic                  grant_found;

    sub_arbiter_sub #(.N(N)) u_sub (
        .a_i    (a_q),
        .b_i    (b_q),
        .diff_o (sub_diff)
    );

    // First valid requester at or after ptr_q, wrapping modulo R.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < R; k++) begin
            if (!grant_found && req_valid[(int'(ptr_q) + k) % R]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(ptr_q) + k) % R);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    // Gated by rst_n so the strobe is silent while reset is held.
                    req_ready = rst_n ? (R'(1) << grant_idx) : '0;
                    state_d   = CALC;
                end
            end
            CALC: state_d = RESP;
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == IDW'(R - 1)) ? '0 : gnt_q + IDW'(1);
                    if (count_q != '1) begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are reset too, so outputs read zero after reset.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (state_q == IDLE && grant_found) begin
                a_q   <= req_a[int'(grant_idx)*N +: N];
                b_q   <= req_b[int'(grant_idx)*N +: N];
                gnt_q <= grant_idx;
            end
            if (state_q == CALC) begin
                diff_q <= sub_diff;
                id_q   <= gnt_q;
            end
        end
    end

    assign res_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign res_diff  = diff_q;
    assign res_id    = id_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// Scoreboard bench for sub_arbiter: stimulus queues expected grants and results,
// negedge monitors pop and compare them as the DUT presents them.

module tb_sub_arbiter;
    localparam int N   = 8;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int CW  = 16;

    logic                clk;
    logic                rst_n;
    logic [R-1:0]        req_valid;
    logic [R*N-1:0]      req_a;
    logic [R*N-1:0]      req_b;
    logic [R-1:0]        req_ready;
    logic                res_valid;
    logic                res_ready;
    logic signed [N+1:0] res_diff;
    logic [IDW-1:0]      res_id;
    logic                busy;
    logic [CW-1:0]       op_count;

    logic [R-1:0]        req_ready2;
    logic                res_valid2;
    logic signed [N+1:0] res_diff2;
    logic [IDW-1:0]      res_id2;
    logic                busy2;
    logic [3:0]          op_count2;

    sub_arbiter #(.N(N), .R(R), .IDW(IDW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_diff(res_diff), .res_id(res_id), .busy(busy), .op_count(op_count)
    );

    sub_arbiter #(.N(N), .R(R), .IDW(IDW), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready2), .res_valid(res_valid2), .res_ready(res_ready),
        .res_diff(res_diff2), .res_id(res_id2), .busy(busy2), .op_count(op_count2)
    );

    typedef struct packed {
        logic [IDW-1:0]      id;
        logic signed [N+1:0] diff;
    } res_t;

    res_t exp_res[$];
    int   exp_gnt[$];
    res_t mon_res;
    int   mon_gnt;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_grant_cyc = 0;
    bit   have_last = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant monitor: every req_ready strobe must match the next expected requester.
    always @(negedge clk) begin
        if (rst_n && req_ready != '0) begin
            if (exp_gnt.size() == 0) begin
                check("grant_unexpected", 32'(req_ready), 32'd0);
            end else begin
                mon_gnt = exp_gnt.pop_front();
                check("grant_onehot", 32'(req_ready), 32'(1) << mon_gnt);
            end
        end
    end

    // Result monitor: compares at the cycle a result handshake is about to complete.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                check("res_unexpected", 32'd1, 32'd0);
            end else begin
                mon_res = exp_res.pop_front();
                check("res_id", 32'(res_id), 32'(mon_res.id));
                check("res_diff", 32'(res_diff), 32'(mon_res.diff));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
    endtask

    task automatic expect_op(input int id, input int diff);
        res_t r;
        r.id   = IDW'(id);
        r.diff = (N+2)'(diff);
        exp_gnt.push_back(id);
        exp_res.push_back(r);
    endtask

    task automatic wait_grants(input int n, input bit chk_interval);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 300) begin
            @(negedge clk);
            budget++;
            if (req_ready != '0) begin
                if (chk_interval && have_last)
                    check("grant_interval", 32'(cyc - last_grant_cyc), 32'd3);
                last_grant_cyc = cyc;
                have_last = 1;
                seen++;
            end
        end
        if (seen < n) check("grant_timeout", 32'(seen), 32'(n));
    endtask

    task automatic wait_idle();
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (busy && budget < 50);
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_res_valid();
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!res_valid && budget < 20);
        if (!res_valid) check("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic do_op(input int i, input int a, input int b, input int diff);
        step();
        set_req(i, a, b);
        req_valid[i] = 1'b1;
        expect_op(i, diff);
        wait_grants(1, 0);
        step();
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_diff",  32'(res_diff),  32'd0);
        check("rst_res_id",    32'(res_id),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single request with latency check: grant at t, res_valid at t+2.
        res_ready = 1'b1;
        step();
        set_req(0, 100, -28);
        req_valid[0] = 1'b1;
        expect_op(0, 128);
        wait_grants(1, 0);
        gc = last_grant_cyc;
        step();
        req_valid[0] = 1'b0;
        wait_res_valid();
        check("latency", 32'(cyc - gc), 32'd2);
        wait_idle();
        check("op_count_1", 32'(op_count), 32'd1);

        // Operand extremes.
        do_op(2, -128, 127, -255);
        do_op(3, 127, -128, 255);
        check("op_count_3", 32'(op_count), 32'd3);

        // Round-robin with all requesters valid, then requester 1 dropped.
        step();
        for (int i = 0; i < R; i++) set_req(i, 10 * (i + 1), i);
        req_valid = 4'b1111;
        expect_op(0, 10); expect_op(1, 19); expect_op(2, 28);
        expect_op(3, 37); expect_op(0, 10); expect_op(1, 19);
        have_last = 0;
        wait_grants(6, 1);
        step();
        req_valid[1] = 1'b0;
        expect_op(2, 28); expect_op(3, 37); expect_op(0, 10); expect_op(2, 28);
        wait_grants(4, 1);
        step();
        req_valid = '0;
        wait_idle();
        check("op_count_rr", 32'(op_count), 32'd13);

        // Backpressure: result held for 5 cycles, pending request must wait.
        res_ready = 1'b0;
        step();
        set_req(1, 5, 9);
        req_valid[1] = 1'b1;
        expect_op(1, -4);
        wait_grants(1, 0);
        step();
        req_valid[1] = 1'b0;
        set_req(0, 1, 1);
        req_valid[0] = 1'b1;
        expect_op(0, 0);
        wait_res_valid();
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_diff",  32'(res_diff),  -32'sd4);
            check("bp_res_id",    32'(res_id),    32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_op_count",  32'(op_count),  32'd13);
        end
        step();
        res_ready = 1'b1;
        @(negedge clk);
        check("hs_no_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("grant_after_hs", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        wait_idle();
        check("op_count_bp", 32'(op_count), 32'd15);

        // Operands change right after grant; the in-flight result must not follow.
        step();
        set_req(3, 10, 3);
        req_valid[3] = 1'b1;
        expect_op(3, 7);
        wait_grants(1, 0);
        step();
        set_req(3, 50, 100);
        req_valid[3] = 1'b0;
        wait_idle();

        // Leave the pointer at 1 so a missing pointer reset is visible later.
        do_op(0, -1, 1, -2);
        check("op_count_pre_rst", 32'(op_count), 32'd17);

        // Asynchronous reset while a result waits in RESP.
        res_ready = 1'b0;
        step();
        set_req(2, 20, 1);
        req_valid[2] = 1'b1;
        exp_gnt.push_back(2);
        wait_grants(1, 0);
        step();
        req_valid[2] = 1'b0;
        wait_res_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_res_diff",  32'(res_diff),  32'd0);
        check("arst_op_count",  32'(op_count),  32'd0);
        for (int i = 0; i < R; i++) set_req(i, 10 * (i + 1), i);
        req_valid = 4'b1111;
        #1;
        check("arst_req_ready_held", 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        step();
        step();
        for (int n = 0; n < 5; n++) begin
            expect_op(0, 10); expect_op(1, 19); expect_op(2, 28); expect_op(3, 37);
        end
        rst_n = 1'b1;

        // Twenty operations: ptr restarts at 0 and the 4-bit counter saturates.
        have_last = 0;
        wait_grants(20, 1);
        step();
        req_valid = '0;
        wait_idle();
        check("op_count_20",  32'(op_count),  32'd20);
        check("op_count_sat", 32'(op_count2), 32'd15);

        repeat (3) @(negedge clk);
        check("sb_grants_drained",  32'(exp_gnt.size()), 32'd0);
        check("sb_results_drained", 32'(exp_res.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
